fma16_vector_recorder: RTL and testbench

Captures FMA16 operation tuples {x, y, z, ctrl, result, flags} into a small FIFO and serializes each one as an ASCII hex text line in the exact 76-bit test-vector format the fma16 testbenches load with `$readmemh`. It sits beside an fma16 instance, on a hardware harness or emulation build, and is the writer end of the vector file: records drained over its byte stream can be saved directly as a `.tv` file.

---
 rtl/fma16_rec_pkg.sv | 17 +
 rtl/fma16_rec_fifo.sv | 37 +++
 rtl/fma16_vector_recorder.sv | 103 ++++++++++
 tb/tb_fma16_vector_recorder.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fma16_rec_pkg.sv
// fma16_rec_pkg: record layout, text-line sizes and hex-to-ASCII helper shared by the vector recorder.
package fma16_rec_pkg;
  localparam int REC_BITS = 76;
  localparam int REC_DIGITS = 19;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic [7:0]  ctrl;
    logic [15:0] result;
    logic [3:0]  flags;
  } rec_t;
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h57 + {4'h0, n};
  endfunction
endpackage

// File: rtl/fma16_rec_fifo.sv
// fma16_rec_fifo: synchronous record FIFO with wrap-bit pointers.
//   clk, reset (async active-low), push/wr_data write side, pop/rd_data read side
//   (rd_data is the head, valid when !empty), full, empty, count = occupancy.
module fma16_rec_fifo
  import fma16_rec_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  rec_t                   wr_data,
  output rec_t                   rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  rec_t mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty = wr_ptr == rd_ptr;
  // same slot index but different lap means the writer is a full lap ahead
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
endmodule

// File: rtl/fma16_vector_recorder.sv
// fma16_vector_recorder: captures fma16 tuples and streams them as lowercase hex .tv text lines.
//   clk, reset (async active-low)
//   cap_valid/cap_ready + x, y, z, ctrl, result, flags: capture side
//   byte_valid/byte_ready/byte_data: ASCII output stream, 19 hex digits then LF per record
//   count: FIFO occupancy, records_sent: completed lines (wraps)
module fma16_vector_recorder
  import fma16_rec_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cap_valid,
  output logic                   cap_ready,
  input  logic [15:0]            x,
  input  logic [15:0]            y,
  input  logic [15:0]            z,
  input  logic [7:0]             ctrl,
  input  logic [15:0]            result,
  input  logic [3:0]             flags,
  output logic                   byte_valid,
  input  logic                   byte_ready,
  output logic [7:0]             byte_data,
  output logic [$clog2(DEPTH):0] count,
  output logic [31:0]            records_sent
);
  typedef enum logic [1:0] {IDLE, DIGIT, NEWLINE} state_t;
  state_t state, state_n;
  rec_t cap_rec, head;
  logic [REC_BITS-1:0] sh, sh_n;
  logic [4:0] idx, idx_n;
  logic [7:0] bd_n;
  logic [31:0] sent_n;
  logic bv_n, full, empty, push, pop, hs;
  assign cap_rec = {x, y, z, ctrl, result, flags};
  assign cap_ready = ~full;
  assign push = cap_valid & cap_ready;
  assign hs = byte_valid & byte_ready;
  fma16_rec_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .wr_data(cap_rec),
    .rd_data(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  // The shift register keeps the digit being presented at its top nibble,
  // so the next digit is always sh[71:68]; idx only tracks how many remain.
  always_comb begin
    state_n = state;
    sh_n = sh;
    idx_n = idx;
    bv_n = byte_valid;
    bd_n = byte_data;
    sent_n = records_sent;
    pop = 1'b0;
    case (state)
      IDLE: pop = ~empty;
      DIGIT:
        if (hs) begin
          state_n = (idx == 5'd0) ? NEWLINE : DIGIT;
          idx_n = idx - 5'd1;
          sh_n = {sh[REC_BITS-5:0], 4'h0};
          bd_n = (idx == 5'd0) ? ASCII_LF : hex_ascii(sh[REC_BITS-5 -: 4]);
        end
      NEWLINE:
        if (hs) begin
          sent_n = records_sent + 32'd1;
          pop = ~empty;
          state_n = IDLE;
          bv_n = 1'b0;
        end
      default: state_n = IDLE;
    endcase
    // loading a record overrides the above so the next line follows the LF without a bubble
    if (pop) begin
      sh_n = head;
      idx_n = 5'(REC_DIGITS - 1);
      state_n = DIGIT;
      bv_n = 1'b1;
      bd_n = hex_ascii(head[REC_BITS-1 -: 4]);
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      sh <= '0;
      idx <= '0;
      byte_valid <= 1'b0;
      byte_data <= 8'h00;
      records_sent <= '0;
    end else begin
      state <= state_n;
      sh <= sh_n;
      idx <= idx_n;
      byte_valid <= bv_n;
      byte_data <= bd_n;
      records_sent <= sent_n;
    end
endmodule

// File: tb/tb_fma16_vector_recorder.sv
// tb_fma16_vector_recorder: randomized self-checking bench against a text-level reference model.
module tb_fma16_vector_recorder;
  localparam int DEPTH = 8;
  logic clk = 0, reset = 0, cap_valid = 0, byte_ready = 0;
  logic [15:0] x = 0, y = 0, z = 0, result = 0;
  logic [7:0] ctrl = 0;
  logic [3:0] flags = 0;
  logic cap_ready, byte_valid;
  logic [7:0] byte_data;
  logic [$clog2(DEPTH):0] count;
  logic [31:0] records_sent;
  int errors = 0, checks = 0, cyc = 0, acc_total = 0, max_count = 0;
  logic [7:0] exp_q[$], rx_q[$];
  int rx_t[$];
  logic prev_stall = 0;
  logic [7:0] prev_data = 0;

  fma16_vector_recorder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .cap_valid(cap_valid), .cap_ready(cap_ready),
    .x(x), .y(y), .z(z), .ctrl(ctrl), .result(result), .flags(flags),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
    .count(count), .records_sent(records_sent)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Sampled mid-cycle: what is seen here is what the next rising edge acts on.
  always @(negedge clk) begin
    if (!reset) prev_stall = 0;
    else begin
      if (prev_stall) begin
        checks++;
        if ({byte_valid, byte_data} !== {1'b1, prev_data}) begin
          errors++;
          $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h", byte_valid, byte_data, prev_data);
        end
      end
      if (byte_valid && byte_ready) begin
        rx_q.push_back(byte_data);
        rx_t.push_back(cyc);
      end
      if (int'(count) > max_count) max_count = int'(count);
      prev_stall = byte_valid && !byte_ready;
      prev_data = byte_data;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: a record is exactly its 76-bit value printed as 19 lowercase hex digits plus LF.
  function automatic void model_add(input logic [75:0] v);
    string s = $sformatf("%019h", v);
    for (int i = 0; i < 19; i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0a);
    acc_total++;
  endfunction

  function automatic logic [75:0] rnd_rec();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[75:0];
  endfunction

  task automatic push(input logic [75:0] v, input int tries, output bit ok);
    {x, y, z, ctrl, result, flags} = v;
    cap_valid = 1;
    ok = 0;
    for (int i = 0; i < tries && !ok; i++) begin
      @(negedge clk);
      ok = cap_ready;
      @(posedge clk);
      #1;
    end
    cap_valid = 0;
    if (ok) model_add(v);
  endtask

  task automatic compare_stream(input string name, input bit gapless);
    for (int i = 0; i < 6000 && rx_q.size() < exp_q.size(); i++) @(posedge clk);
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_length: got %0d bytes, required %0d", name, rx_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s_byte%0d: got %h, required %h", name, i, rx_q[i], exp_q[i]);
        end
      end
      if (gapless && rx_q.size() > 0) begin
        checks++;
        if (rx_t[$] - rx_t[0] != rx_q.size() - 1) begin
          errors++;
          $display("FAIL %s_gapless: span %0d cycles, required %0d", name, rx_t[$] - rx_t[0], rx_q.size() - 1);
        end
      end
    end
  endtask

  task automatic close_stream(input string name);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (records_sent !== 32'(acc_total)) begin
      errors++;
      $display("FAIL %s_records_sent: got %0d, required %0d", name, records_sent, acc_total);
    end
    exp_q.delete();
    rx_q.delete();
    rx_t.delete();
  endtask

  task automatic check_reset_values(input string name);
    checks += 5;
    if (cap_ready !== 1'b1) begin errors++; $display("FAIL %s_cap_ready: got %b, required 1", name, cap_ready); end
    if (byte_valid !== 1'b0) begin errors++; $display("FAIL %s_byte_valid: got %b, required 0", name, byte_valid); end
    if (byte_data !== 8'h00) begin errors++; $display("FAIL %s_byte_data: got %h, required 00", name, byte_data); end
    if (count !== '0) begin errors++; $display("FAIL %s_count: got %0d, required 0", name, count); end
    if (records_sent !== 32'd0) begin errors++; $display("FAIL %s_records_sent: got %0d, required 0", name, records_sent); end
  endtask

  task automatic test_reset;
    reset = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk);
    #1;
    reset = 1;
  endtask

  task automatic test_single;
    bit ok;
    int c1;
    byte_ready = 1;
    push(76'h3c00400000000840000, 1, ok);
    @(negedge clk);
    c1 = cyc;
    checks += 2;
    if (!ok) begin errors++; $display("FAIL single_accept: cap_ready=0, required 1"); end
    if (count !== 4'd1) begin errors++; $display("FAIL single_count: got %0d, required 1", count); end
    compare_stream("single", 1);
    checks += 3;
    if (rx_t.size() == 0 || rx_t[0] != c1 + 1) begin
      errors++;
      $display("FAIL single_latency: first byte cycle %0d, required %0d", rx_t.size() ? rx_t[0] : -1, c1 + 1);
    end
    if (rx_q.size() < 20 || rx_q[0] !== 8'h33) begin errors++; $display("FAIL single_first: got %h, required 33", rx_q.size() ? rx_q[0] : 8'hxx); end
    if (rx_q.size() < 20 || rx_q[19] !== 8'h0a) begin errors++; $display("FAIL single_lf: got %h, required 0a", rx_q.size() > 19 ? rx_q[19] : 8'hxx); end
    close_stream("single");
  endtask

  task automatic test_hex_letters;
    bit ok;
    logic [7:0] want [5] = '{8'h66, 8'h62, 8'h66, 8'h66, 8'h61};
    int pos [5] = '{0, 1, 2, 3, 18};
    byte_ready = 1;
    push(76'hfbffabcdef01037c00a, 1, ok);
    compare_stream("hex", 1);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rx_q.size() < 20 || rx_q[pos[i]] !== want[i]) begin
        errors++;
        $display("FAIL hex_char%0d: got %h, required %h", pos[i], rx_q.size() > pos[i] ? rx_q[pos[i]] : 8'hxx, want[i]);
      end
    end
    close_stream("hex");
  endtask

  task automatic test_backpressure;
    bit ok;
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          push(rnd_rec(), 500, ok);
          repeat ($urandom_range(0, 5)) @(posedge clk);
          #1;
        end
      end
      begin
        for (int i = 0; i < 4000 && rx_q.size() < 100; i++) begin
          @(posedge clk);
          #1;
          byte_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    byte_ready = 1;
    compare_stream("backpressure", 0);
    close_stream("backpressure");
  endtask

  task automatic test_full;
    bit ok;
    byte_ready = 0;
    for (int k = 0; k < DEPTH + 2; k++) push(rnd_rec(), 1, ok);
    @(negedge clk);
    checks += 3;
    if (cap_ready !== 1'b0) begin errors++; $display("FAIL full_cap_ready: got %b, required 0", cap_ready); end
    if (int'(count) != DEPTH) begin errors++; $display("FAIL full_count: got %0d, required %0d", count, DEPTH); end
    if (byte_valid !== 1'b1 || byte_data !== exp_q[0]) begin
      errors++;
      $display("FAIL full_stalled_head: valid=%b data=%h, required valid=1 data=%h", byte_valid, byte_data, exp_q[0]);
    end
    @(posedge clk);
    #1;
    byte_ready = 1;
    compare_stream("full", 1);
    close_stream("full");
  endtask

  task automatic test_back_to_back;
    bit ok;
    byte_ready = 1;
    max_count = 0;
    for (int k = 0; k < 6; k++) begin
      push(rnd_rec(), 1, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL stream_accept%0d: cap_ready=0, required 1", k); end
      repeat (19) @(posedge clk);
      #1;
    end
    compare_stream("stream", 1);
    checks++;
    if (max_count > 1) begin errors++; $display("FAIL stream_max_count: got %0d, required <=1", max_count); end
    close_stream("stream");
  endtask

  task automatic test_reset_midline;
    bit ok;
    byte_ready = 1;
    push(rnd_rec(), 1, ok);
    push(rnd_rec(), 1, ok);
    for (int i = 0; i < 200 && rx_q.size() < 7; i++) @(posedge clk);
    checks++;
    if (rx_q.size() != 7) begin errors++; $display("FAIL midline_progress: got %0d digits, required 7", rx_q.size()); end
    #1;
    reset = 0;
    #1;
    check_reset_values("midline");
    exp_q.delete();
    rx_q.delete();
    rx_t.delete();
    acc_total = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (byte_valid !== 1'b0) begin errors++; $display("FAIL midline_no_lf: valid=%b, required 0", byte_valid); end
    @(posedge clk);
    #1;
    push(rnd_rec(), 1, ok);
    compare_stream("midline", 1);
    close_stream("midline");
  endtask

  initial begin
    test_reset();
    test_single();
    test_hex_letters();
    test_backpressure();
    test_full();
    test_back_to_back();
    test_reset_midline();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
